lbb_master: RTL and testbench

LBB_MASTER -- requirements
Module: lbb_master

---
 rtl/lbb_master.sv | 245 ++++++++++++++++++++++++
 tb/tb_lbb_master.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lbb_master.sv
// lbb_master: local-bus burst master (LHOLD/ADS/BLAST handshake), splitting bursts at 16-byte lines.
// Define LBM_TIMEOUT_EN to abort a data phase after 255 idle DATA cycles (reported on O_ERR).
`timescale 1ns/1ps
module lbb_master (
  input  logic        I_LCLK,
  input  logic        I_RESET,
  input  logic        I_CMD_VALID,
  output logic        O_CMD_READY,
  input  logic        I_CMD_WRITE,
  input  logic [29:0] I_CMD_ADDR,
  input  logic [1:0]  I_CMD_BEATS,
  input  logic [3:0]  I_CMD_BE,
  input  logic [31:0] I_WDATA,
  output logic        O_WDATA_ACK,
  output logic [31:0] O_RDATA,
  output logic        O_RDATA_VALID,
  output logic        O_DONE,
  output logic        O_ERR,
  output logic        O_LHOLD,
  input  logic        I_LHOLDA,
  output logic        ON_ADS,
  output logic        ON_BLAST,
  output logic        ON_LWR,
  output logic [3:0]  ON_LBE,
  output logic [31:0] O_LAD,
  output logic        O_LAD_OE,
  input  logic [31:0] I_LAD,
  input  logic        IN_READY,
  input  logic        IN_BTERM
);
  typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_ADDR, ST_DATA, ST_RECOV} state_e;

  state_e      state_q, state_d;
  logic        write_q, write_d;
  logic [29:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [2:0]  left_q, left_d;
  logic [2:0]  phase_q, phase_d;
  logic        lhold_q, lhold_d;
  logic        ads_n_q, ads_n_d;
  logic        blast_n_q, blast_n_d;
  logic        lwr_n_q, lwr_n_d;
  logic [3:0]  lbe_n_q, lbe_n_d;
  logic [31:0] lad_q, lad_d;
  logic        lad_oe_q, lad_oe_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic        done_q, done_d;
  logic        beat_done, finish;
  logic [29:0] addr_inc;
  logic [2:0]  left_dec, phase_dec;
`ifdef LBM_TIMEOUT_EN
  logic [7:0]  tmo_q, tmo_d;
  logic        err_q, err_d;
`endif

  // Beats that fit before the next 16-byte line boundary.
  function automatic logic [2:0] phase_len(input logic [1:0] word_in_line, input logic [2:0] n);
    logic [2:0] room;
    room = 3'd4 - {1'b0, word_in_line};
    return (n < room) ? n : room;
  endfunction

  assign beat_done = (state_q == ST_DATA) && (!IN_READY || !IN_BTERM);
  assign addr_inc  = addr_q + 30'd1;
  assign left_dec  = left_q - 3'd1;
  assign phase_dec = phase_q - 3'd1;

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    addr_d      = addr_q;
    be_d        = be_q;
    left_d      = left_q;
    phase_d     = phase_q;
    lhold_d     = lhold_q;
    ads_n_d     = ads_n_q;
    blast_n_d   = blast_n_q;
    lwr_n_d     = lwr_n_q;
    lbe_n_d     = lbe_n_q;
    lad_d       = lad_q;
    lad_oe_d    = lad_oe_q;
    cmd_ready_d = cmd_ready_q;
    rdata_d     = rdata_q;
    rvalid_d    = 1'b0;
    done_d      = 1'b0;
    finish      = 1'b0;
`ifdef LBM_TIMEOUT_EN
    tmo_d       = tmo_q;
    err_d       = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        if (I_CMD_VALID && cmd_ready_q) begin
          write_d     = I_CMD_WRITE;
          addr_d      = I_CMD_ADDR;
          be_d        = I_CMD_BE;
          left_d      = {1'b0, I_CMD_BEATS} + 3'd1;
          lhold_d     = 1'b1;
          cmd_ready_d = 1'b0;
          state_d     = ST_REQ;
        end
      end
      ST_REQ: begin
        if (I_LHOLDA) begin
          state_d  = ST_ADDR;
          ads_n_d  = 1'b0;
          lad_d    = {addr_q, 2'b00};
          lad_oe_d = 1'b1;
          lwr_n_d  = ~write_q;
          lbe_n_d  = ~be_q;
          phase_d  = phase_len(addr_q[1:0], left_q);
        end
      end
      ST_ADDR: begin
        state_d   = ST_DATA;
        ads_n_d   = 1'b1;
        lad_d     = '0;
        lad_oe_d  = write_q;
        blast_n_d = (phase_q != 3'd1);
`ifdef LBM_TIMEOUT_EN
        tmo_d     = '0;
`endif
      end
      ST_DATA: begin
        if (beat_done) begin
          rvalid_d = ~write_q;
          if (!write_q) rdata_d = I_LAD;
          addr_d  = addr_inc;
          left_d  = left_dec;
          phase_d = phase_dec;
`ifdef LBM_TIMEOUT_EN
          tmo_d   = '0;
`endif
          if (left_q == 3'd1) begin
            finish = 1'b1;
          end else if (!IN_BTERM || phase_q == 3'd1) begin
            // Re-arbitration is not needed: LHOLD stays up and a fresh address phase starts.
            state_d   = ST_ADDR;
            ads_n_d   = 1'b0;
            blast_n_d = 1'b1;
            lad_d     = {addr_inc, 2'b00};
            lad_oe_d  = 1'b1;
            phase_d   = phase_len(addr_inc[1:0], left_dec);
          end else begin
            blast_n_d = (phase_dec != 3'd1);
          end
        end
`ifdef LBM_TIMEOUT_EN
        else if (tmo_q == 8'hFF) begin
          finish = 1'b1;
          err_d  = 1'b1;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
`endif
      end
      ST_RECOV: begin
        state_d     = ST_IDLE;
        cmd_ready_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (finish) begin
      state_d   = ST_RECOV;
      lhold_d   = 1'b0;
      done_d    = 1'b1;
      ads_n_d   = 1'b1;
      blast_n_d = 1'b1;
      lwr_n_d   = 1'b1;
      lbe_n_d   = '1;
      lad_d     = '0;
      lad_oe_d  = 1'b0;
    end
  end

  always_ff @(posedge I_LCLK or posedge I_RESET) begin
    if (I_RESET) begin
      state_q     <= ST_IDLE;
      write_q     <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      left_q      <= '0;
      phase_q     <= '0;
      lhold_q     <= 1'b0;
      ads_n_q     <= 1'b1;
      blast_n_q   <= 1'b1;
      lwr_n_q     <= 1'b1;
      lbe_n_q     <= '1;
      lad_q       <= '0;
      lad_oe_q    <= 1'b0;
      cmd_ready_q <= 1'b0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      done_q      <= 1'b0;
`ifdef LBM_TIMEOUT_EN
      tmo_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      left_q      <= left_d;
      phase_q     <= phase_d;
      lhold_q     <= lhold_d;
      ads_n_q     <= ads_n_d;
      blast_n_q   <= blast_n_d;
      lwr_n_q     <= lwr_n_d;
      lbe_n_q     <= lbe_n_d;
      lad_q       <= lad_d;
      lad_oe_q    <= lad_oe_d;
      cmd_ready_q <= cmd_ready_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      done_q      <= done_d;
`ifdef LBM_TIMEOUT_EN
      tmo_q       <= tmo_d;
      err_q       <= err_d;
`endif
    end
  end

  // Write data and its ack bypass the output flops so the host can advance data on the completing edge.
  assign O_WDATA_ACK   = beat_done && write_q;
  assign O_LAD         = (state_q == ST_DATA && write_q) ? I_WDATA : lad_q;
  assign O_LAD_OE      = lad_oe_q;
  assign O_LHOLD       = lhold_q;
  assign ON_ADS        = ads_n_q;
  assign ON_BLAST      = blast_n_q;
  assign ON_LWR        = lwr_n_q;
  assign ON_LBE        = lbe_n_q;
  assign O_CMD_READY   = cmd_ready_q;
  assign O_RDATA       = rdata_q;
  assign O_RDATA_VALID = rvalid_q;
  assign O_DONE        = done_q;
`ifdef LBM_TIMEOUT_EN
  assign O_ERR         = err_q;
`else
  assign O_ERR         = 1'b0;
`endif
endmodule

// File: tb/tb_lbb_master.sv
// Self-checking bench for lbb_master: a bus-slave monitor drives READY/BTERM and pops scoreboard queues.
`timescale 1ns/1ps
module tb_lbb_master;
  logic        clk = 1'b0;
  logic        rst;
  logic        I_CMD_VALID, I_CMD_WRITE;
  logic [29:0] I_CMD_ADDR;
  logic [1:0]  I_CMD_BEATS;
  logic [3:0]  I_CMD_BE;
  logic [31:0] I_WDATA, I_LAD;
  logic        I_LHOLDA, IN_READY, IN_BTERM;
  logic        O_CMD_READY, O_WDATA_ACK, O_RDATA_VALID, O_DONE, O_ERR;
  logic [31:0] O_RDATA, O_LAD;
  logic        O_LHOLD, ON_ADS, ON_BLAST, ON_LWR, O_LAD_OE;
  logic [3:0]  ON_LBE;

  lbb_master dut (
    .I_LCLK(clk), .I_RESET(rst),
    .I_CMD_VALID(I_CMD_VALID), .O_CMD_READY(O_CMD_READY), .I_CMD_WRITE(I_CMD_WRITE),
    .I_CMD_ADDR(I_CMD_ADDR), .I_CMD_BEATS(I_CMD_BEATS), .I_CMD_BE(I_CMD_BE),
    .I_WDATA(I_WDATA), .O_WDATA_ACK(O_WDATA_ACK), .O_RDATA(O_RDATA),
    .O_RDATA_VALID(O_RDATA_VALID), .O_DONE(O_DONE), .O_ERR(O_ERR),
    .O_LHOLD(O_LHOLD), .I_LHOLDA(I_LHOLDA), .ON_ADS(ON_ADS), .ON_BLAST(ON_BLAST),
    .ON_LWR(ON_LWR), .ON_LBE(ON_LBE), .O_LAD(O_LAD), .O_LAD_OE(O_LAD_OE),
    .I_LAD(I_LAD), .IN_READY(IN_READY), .IN_BTERM(IN_BTERM)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  logic [29:0] exp_ads_q[$];
  logic [31:0] exp_rd_q[$];
  logic [31:0] exp_wr_q[$];

  // monitor-owned state
  int n_ads = 0, n_ack = 0, n_rv = 0, n_done = 0, n_err = 0, blast_low = 0;
  bit in_data = 0, ack_pend = 0;
  int wcnt = 0, beat_no = 0, wbeat = 0, hold_cnt = 0;
  logic [29:0] cur_addr, mon_ea;
  logic [31:0] mon_ev;

  // test-owned configuration
  int lholda_dly = 0, wait_st = 0, bterm_at = -1;
  bit never_ready = 0, drop_holda = 0, cur_wr = 0;
  logic [3:0] cur_be = 4'hF;
  int b_ads, b_ack, b_rv, b_done, b_err, b_bl;

  function automatic logic [31:0] rd_fn(input logic [29:0] a);
    return 32'hC0DE_0000 ^ {a[15:0], ~a[15:0]};
  endfunction
  function automatic logic [31:0] wd_fn(input int i);
    return 32'h5A00_0000 + 32'(i);
  endfunction

  // Bus slave + output monitor, sampling on the falling edge.
  initial begin
    I_LHOLDA = 0; IN_READY = 1; IN_BTERM = 1; I_LAD = '0; I_WDATA = wd_fn(0); cur_addr = '0;
    forever begin
      @(negedge clk);
      if (ack_pend) begin wbeat++; ack_pend = 0; end
      if (rst === 1'b1) begin
        in_data = 0; I_LHOLDA = 0; hold_cnt = 0; IN_READY = 1; IN_BTERM = 1; wbeat = 0; beat_no = 0;
      end else begin
        if (O_LHOLD !== 1'b1) begin wbeat = 0; beat_no = 0; in_data = 0; end
        if (O_LHOLD === 1'b1) begin
          if (hold_cnt >= lholda_dly) I_LHOLDA = 1;
          hold_cnt++;
        end else begin
          I_LHOLDA = 0; hold_cnt = 0;
        end
        if (drop_holda && in_data) I_LHOLDA = 0;
        if (O_RDATA_VALID === 1'b1) begin
          n_rv++; checks++;
          if (exp_rd_q.size() == 0) begin
            errors++; $display("FAIL rdata_extra: got %h, none expected", O_RDATA);
          end else begin
            mon_ev = exp_rd_q.pop_front();
            if (O_RDATA !== mon_ev) begin errors++; $display("FAIL rdata: got %h expected %h", O_RDATA, mon_ev); end
          end
        end
        if (O_DONE === 1'b1) n_done++;
        if (O_ERR === 1'b1) n_err++;
        IN_READY = 1; IN_BTERM = 1;
        if (ON_ADS === 1'b0) begin
          n_ads++; checks++;
          if (exp_ads_q.size() == 0) begin
            errors++; $display("FAIL ads_extra: got lad=%h, none expected", O_LAD);
          end else begin
            mon_ea = exp_ads_q.pop_front();
            if (O_LAD !== {mon_ea, 2'b00} || O_LAD_OE !== 1'b1 || ON_LWR !== !cur_wr || ON_LBE !== ~cur_be) begin
              errors++;
              $display("FAIL ads: got lad=%h oe=%b lwr=%b lbe=%h expected lad=%h oe=1 lwr=%b lbe=%h",
                       O_LAD, O_LAD_OE, ON_LWR, ON_LBE, {mon_ea, 2'b00}, !cur_wr, ~cur_be);
            end
          end
          cur_addr = O_LAD[31:2]; in_data = 1; wcnt = 0;
        end else if (in_data) begin
          checks++;
          if (O_LAD_OE !== cur_wr || ON_LWR !== !cur_wr) begin
            errors++; $display("FAIL data_drive: got oe=%b lwr=%b expected oe=%b lwr=%b", O_LAD_OE, ON_LWR, cur_wr, !cur_wr);
          end
          if (ON_BLAST === 1'b0) blast_low++;
          if (!never_ready && wcnt >= wait_st) begin
            if (beat_no == bterm_at) IN_BTERM = 0; else IN_READY = 0;
            I_LAD = rd_fn(cur_addr);
            if (ON_BLAST === 1'b0 || beat_no == bterm_at) in_data = 0;
            cur_addr++; beat_no++; wcnt = 0;
          end else begin
            wcnt++;
          end
        end
      end
      I_WDATA = wd_fn(wbeat);
      #1;
      if (O_WDATA_ACK === 1'b1) begin
        n_ack++; ack_pend = 1; checks++;
        if (exp_wr_q.size() == 0) begin
          errors++; $display("FAIL wack_extra: got lad=%h, none expected", O_LAD);
        end else begin
          mon_ev = exp_wr_q.pop_front();
          if (O_LAD !== mon_ev || O_LAD_OE !== 1'b1) begin
            errors++; $display("FAIL wdata: got lad=%h oe=%b expected lad=%h oe=1", O_LAD, O_LAD_OE, mon_ev);
          end
        end
      end
    end
  end

  task automatic snap();
    b_ads = n_ads; b_ack = n_ack; b_rv = n_rv; b_done = n_done; b_err = n_err; b_bl = blast_low;
  endtask

  task automatic issue(input bit wr, input logic [29:0] a, input logic [1:0] beats, input logic [3:0] be);
    int t;
    t = 0;
    while (O_CMD_READY !== 1'b1 && t < 50) begin @(negedge clk); #2; t++; end
    checks++;
    if (O_CMD_READY !== 1'b1) begin errors++; $display("FAIL cmd_ready_wait: got %b expected 1", O_CMD_READY); end
    cur_wr = wr; cur_be = be;
    snap();
    I_CMD_WRITE = wr; I_CMD_ADDR = a; I_CMD_BEATS = beats; I_CMD_BE = be; I_CMD_VALID = 1;
    @(negedge clk); #2;
    I_CMD_VALID = 0;
  endtask

  task automatic wait_done(input int budget, output int cyc, output bit ok);
    ok = 0; cyc = 0;
    while (!ok && cyc < budget) begin
      @(negedge clk); #2; cyc++;
      if (n_done != b_done) ok = 1;
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    #2;
    checks++;
    if ({O_LHOLD, ON_ADS, ON_BLAST, ON_LWR, ON_LBE, O_LAD_OE, O_CMD_READY, O_DONE, O_RDATA_VALID, O_ERR}
        !== {1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_ctrl: got lhold=%b ads=%b blast=%b lwr=%b lbe=%h oe=%b rdy=%b done=%b rv=%b err=%b expected 0 1 1 1 f 0 0 0 0 0",
               O_LHOLD, ON_ADS, ON_BLAST, ON_LWR, ON_LBE, O_LAD_OE, O_CMD_READY, O_DONE, O_RDATA_VALID, O_ERR);
    end
    checks++;
    if (O_LAD !== 32'h0) begin errors++; $display("FAIL reset_lad: got %h expected 0", O_LAD); end
    rst = 0;
    @(negedge clk); #2;
    checks++;
    if (O_CMD_READY !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b expected 1", O_CMD_READY); end
  endtask

  task automatic test_single_read();
    int cyc; bit ok;
    lholda_dly = 2; wait_st = 2;
    exp_ads_q.push_back(30'h1000);
    exp_rd_q.push_back(rd_fn(30'h1000));
    issue(0, 30'h1000, 2'd0, 4'hF);
    wait_done(100, cyc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL sr_done: got none expected O_DONE"); end
    checks++; if (n_ads - b_ads != 1) begin errors++; $display("FAIL sr_ads: got %0d expected 1", n_ads - b_ads); end
    checks++; if (n_rv - b_rv != 1) begin errors++; $display("FAIL sr_rvalid: got %0d expected 1", n_rv - b_rv); end
    checks++; if (blast_low - b_bl != 3) begin errors++; $display("FAIL sr_blast: got %0d expected 3", blast_low - b_bl); end
    @(negedge clk); #2;
    checks++; if (n_done - b_done != 1) begin errors++; $display("FAIL sr_done_count: got %0d expected 1", n_done - b_done); end
    checks++; if (O_CMD_READY !== 1'b1) begin errors++; $display("FAIL sr_ready: got %b expected 1", O_CMD_READY); end
    lholda_dly = 0; wait_st = 0;
  endtask

  task automatic test_burst_write();
    int cyc; bit ok;
    drop_holda = 1;
    exp_ads_q.push_back(30'h2000);
    for (int i = 0; i < 4; i++) exp_wr_q.push_back(wd_fn(i));
    issue(1, 30'h2000, 2'd3, 4'hA);
    wait_done(100, cyc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bw_done: got none expected O_DONE"); end
    checks++;
    if (O_LHOLD !== 1'b0 || ON_ADS !== 1'b1 || ON_BLAST !== 1'b1 || O_LAD_OE !== 1'b0) begin
      errors++; $display("FAIL bw_recov: got lhold=%b ads=%b blast=%b oe=%b expected 0 1 1 0", O_LHOLD, ON_ADS, ON_BLAST, O_LAD_OE);
    end
    checks++; if (n_ack - b_ack != 4) begin errors++; $display("FAIL bw_acks: got %0d expected 4", n_ack - b_ack); end
    checks++; if (n_ads - b_ads != 1) begin errors++; $display("FAIL bw_ads: got %0d expected 1", n_ads - b_ads); end
    checks++; if (blast_low - b_bl != 1) begin errors++; $display("FAIL bw_blast: got %0d expected 1", blast_low - b_bl); end
    drop_holda = 0;
  endtask

  task automatic test_line_split_read();
    int cyc; bit ok;
    wait_st = 1;
    exp_ads_q.push_back(30'h3002);
    exp_ads_q.push_back(30'h3004);
    for (int i = 0; i < 4; i++) exp_rd_q.push_back(rd_fn(30'h3002 + 30'(i)));
    issue(0, 30'h3002, 2'd3, 4'hF);
    wait_done(100, cyc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ls_done: got none expected O_DONE"); end
    checks++; if (n_ads - b_ads != 2) begin errors++; $display("FAIL ls_ads: got %0d expected 2", n_ads - b_ads); end
    checks++; if (n_rv - b_rv != 4) begin errors++; $display("FAIL ls_rvalid: got %0d expected 4", n_rv - b_rv); end
    checks++; if (blast_low - b_bl != 4) begin errors++; $display("FAIL ls_blast: got %0d expected 4", blast_low - b_bl); end
    wait_st = 0;
  endtask

  task automatic test_bterm_write();
    int cyc; bit ok;
    bterm_at = 1;
    exp_ads_q.push_back(30'h4000);
    exp_ads_q.push_back(30'h4002);
    for (int i = 0; i < 4; i++) exp_wr_q.push_back(wd_fn(i));
    issue(1, 30'h4000, 2'd3, 4'hF);
    wait_done(100, cyc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bt_done: got none expected O_DONE"); end
    checks++; if (n_ack - b_ack != 4) begin errors++; $display("FAIL bt_acks: got %0d expected 4", n_ack - b_ack); end
    checks++; if (n_ads - b_ads != 2) begin errors++; $display("FAIL bt_ads: got %0d expected 2", n_ads - b_ads); end
    checks++; if (blast_low - b_bl != 1) begin errors++; $display("FAIL bt_blast: got %0d expected 1", blast_low - b_bl); end
    repeat (3) @(negedge clk); #2;
    checks++; if (n_done - b_done != 1) begin errors++; $display("FAIL bt_done_count: got %0d expected 1", n_done - b_done); end
    bterm_at = -1;
  endtask

  task automatic test_addr_wrap();
    int cyc; bit ok;
    exp_ads_q.push_back(30'h3FFF_FFFF);
    exp_ads_q.push_back(30'h0);
    exp_rd_q.push_back(rd_fn(30'h3FFF_FFFF));
    exp_rd_q.push_back(rd_fn(30'h0));
    issue(0, 30'h3FFF_FFFF, 2'd1, 4'h3);
    wait_done(100, cyc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wr_done: got none expected O_DONE"); end
    checks++; if (n_ads - b_ads != 2) begin errors++; $display("FAIL wrap_ads: got %0d expected 2", n_ads - b_ads); end
    checks++; if (blast_low - b_bl != 2) begin errors++; $display("FAIL wrap_blast: got %0d expected 2", blast_low - b_bl); end
  endtask

  task automatic test_timeout();
    int cyc, t; bit ok;
    never_ready = 1;
    exp_ads_q.push_back(30'h7000);
    issue(0, 30'h7000, 2'd3, 4'hF);
    t = 0;
    while (n_ads == b_ads && t < 20) begin @(negedge clk); #2; t++; end
    checks++; if (n_ads == b_ads) begin errors++; $display("FAIL to_ads: got none expected ADS"); end
`ifdef LBM_TIMEOUT_EN
    wait_done(400, cyc, ok);
    checks++; if (!ok || cyc != 257) begin errors++; $display("FAIL to_latency: got done=%b after %0d cycles expected 1 after 257", ok, cyc); end
    checks++; if (n_err - b_err != 1) begin errors++; $display("FAIL to_err: got %0d expected 1", n_err - b_err); end
    checks++; if (n_rv != b_rv) begin errors++; $display("FAIL to_rvalid: got %0d expected 0", n_rv - b_rv); end
    @(negedge clk); #2;
    checks++; if (O_CMD_READY !== 1'b1) begin errors++; $display("FAIL to_idle: got ready=%b expected 1", O_CMD_READY); end
    never_ready = 0;
`else
    wait_done(1000, cyc, ok);
    checks++; if (ok) begin errors++; $display("FAIL to_nodone: got O_DONE after %0d cycles expected none", cyc); end
    checks++; if (n_err != b_err) begin errors++; $display("FAIL to_err: got %0d expected 0", n_err - b_err); end
    never_ready = 0;
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
`endif
  endtask

  task automatic test_reset_in_data();
    int cyc, t; bit ok;
    wait_st = 5;
    exp_ads_q.push_back(30'h5000);
    issue(0, 30'h5000, 2'd3, 4'hF);
    t = 0;
    while (!in_data && t < 20) begin @(negedge clk); #2; t++; end
    @(negedge clk);
    rst = 1;
    #1;
    checks++;
    if (O_LHOLD !== 1'b0 || ON_ADS !== 1'b1 || ON_BLAST !== 1'b1 || O_LAD_OE !== 1'b0 ||
        O_LAD !== 32'h0 || ON_LBE !== 4'hF || ON_LWR !== 1'b1) begin
      errors++;
      $display("FAIL rst_bus_idle: got lhold=%b ads=%b blast=%b oe=%b lad=%h lbe=%h lwr=%b expected 0 1 1 0 0 f 1",
               O_LHOLD, ON_ADS, ON_BLAST, O_LAD_OE, O_LAD, ON_LBE, ON_LWR);
    end
    repeat (2) @(negedge clk);
    rst = 0;
    wait_st = 0;
    repeat (10) @(negedge clk);
    #2;
    checks++; if (n_done != b_done) begin errors++; $display("FAIL rst_nodone: got %0d expected 0", n_done - b_done); end
    exp_ads_q.push_back(30'h6001);
    exp_rd_q.push_back(rd_fn(30'h6001));
    issue(0, 30'h6001, 2'd0, 4'hF);
    wait_done(100, cyc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_next_done: got none expected O_DONE"); end
    checks++; if (n_rv - b_rv != 1) begin errors++; $display("FAIL rst_next_rvalid: got %0d expected 1", n_rv - b_rv); end
  endtask

  initial begin
    rst = 1; I_CMD_VALID = 0; I_CMD_WRITE = 0; I_CMD_ADDR = '0; I_CMD_BEATS = '0; I_CMD_BE = '0;
    test_reset();
    test_single_read();
    test_burst_write();
    test_line_split_read();
    test_bterm_write();
    test_addr_wrap();
    test_timeout();
    test_reset_in_data();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_ads_q.size() + exp_rd_q.size() + exp_wr_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: got ads=%0d rd=%0d wr=%0d expected 0 0 0", exp_ads_q.size(), exp_rd_q.size(), exp_wr_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got time limit expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
